// File: rtl/sync_serial_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_serial_rx_pkg                                                |
// | Brief   : Shared frame-state encoding and line level for the serial link.   |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package sync_serial_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  localparam logic c_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_serial_rx_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_2ff                                                          |
// | Brief   : Two-flop synchronizer with configurable reset value.              |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sync_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_serial_rx                                                    |
// | Brief   : Serial-link receiver, LSB-first, mid-bit sampling, stop check.    |
// |           Define SYNC_SERIAL_PARITY_EN to add an even-parity bit.           |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sync_serial_rx
  import sync_serial_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int c_CW = $clog2(CLKS_PER_BIT);
  localparam int c_BW = $clog2(DATA_W + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_CNT_MID  = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_W - 1);

  logic              w_rx_s;
  logic              r_rx_d;
  rx_state_e         r_state,   w_state_nxt;
  logic [c_CW-1:0]   r_clk_cnt, w_clk_cnt_nxt;
  logic [c_BW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0] r_shift,   w_shift_nxt;
  logic              w_done_ok;
  logic              w_done_err;
`ifdef SYNC_SERIAL_PARITY_EN
  logic              r_par_bad, w_par_bad_nxt;
`endif

  sync_2ff #(
    .RST_VAL (c_IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_d    <= c_IDLE_LEVEL;
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef SYNC_SERIAL_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_rx_d    <= w_rx_s;
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
`ifdef SYNC_SERIAL_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  // Counter is realigned at mid-start, so every later full-bit wrap lands mid-bit.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_done_ok     = 1'b0;
    w_done_err    = 1'b0;
`ifdef SYNC_SERIAL_PARITY_EN
    w_par_bad_nxt = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_rx_d && !w_rx_s) begin
          w_state_nxt   = S_START;
          w_clk_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (r_clk_cnt == c_CNT_MID) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == c_CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = (r_shift >> 1) | (DATA_W'(w_rx_s) << (DATA_W - 1));
          if (r_bit_cnt == c_BIT_LAST) begin
            w_bit_cnt_nxt = '0;
`ifdef SYNC_SERIAL_PARITY_EN
            w_state_nxt   = S_PARITY;
`else
            w_state_nxt   = S_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
`ifdef SYNC_SERIAL_PARITY_EN
      S_PARITY: begin
        if (r_clk_cnt == c_CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_par_bad_nxt = (^r_shift) ^ w_rx_s;
          w_state_nxt   = S_STOP;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (r_clk_cnt == c_CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
`ifdef SYNC_SERIAL_PARITY_EN
          w_done_ok     = w_rx_s && !r_par_bad;
`else
          w_done_ok     = w_rx_s;
`endif
          w_done_err    = !w_done_ok;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= w_done_ok;
      frame_err <= w_done_err;
      if (w_done_ok) begin
        rx_data <= r_shift;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sync_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sync_serial_rx                                                 |
// | Brief   : Directed frames against a timing/scoreboard model of the receiver.|
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sync_serial_rx;

  localparam int DW  = 8;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  sync_serial_rx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = frame dropped silently, 1 = rx_valid, 2 = frame_err
  typedef struct {
    int            t_from;
    int            t_end;
    int            kind;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           q[$];
  logic [DW-1:0] md = '0;
  int            total = 0;
  int            bad = 0;
  int            n_valid = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_v, exp_e, exp_b;
      exp_v = 1'b0;
      exp_e = 1'b0;
      exp_b = 1'b0;
      if (q.size() > 0 && q[0].t_end == cyc) begin
        ev_t e;
        e = q.pop_front();
        if (e.kind == 1) begin
          exp_v = 1'b1;
          md    = e.data;
        end else if (e.kind == 2) begin
          exp_e = 1'b1;
        end
      end
      foreach (q[i]) if (cyc >= q[i].t_from && cyc < q[i].t_end) exp_b = 1'b1;
      if (rx_valid)  n_valid++;
      if (frame_err) n_err++;
      chk("rx_valid",  32'(rx_valid),  32'(exp_v));
      chk("frame_err", 32'(frame_err), 32'(exp_e));
      chk("busy",      32'(busy),      32'(exp_b));
      chk("rx_data",   32'(rx_data),   32'(md));
    end
  end

  task automatic wait_bit(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    q.delete();
    md    = '0;
    wait_bit(1);
    rst_n = 1'b1;
  endtask

  // Called at #1 after a posedge; returns at #1 after a posedge.
  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                            input int abort_bit);
    ev_t  e;
    logic ok;
    int   lat;
    lat = 2 + CPB / 2 + (DW + 1) * CPB + 1;
    ok  = stop;
`ifdef SYNC_SERIAL_PARITY_EN
    lat = lat + CPB;
    ok  = stop && (((^d) ^ par) == 1'b0);
`endif
    e.t_from = cyc + 3;
    e.t_end  = cyc + lat;
    e.kind   = ok ? 1 : 2;
    e.data   = d;
    q.push_back(e);
    rx = 1'b0;
    wait_bit(CPB);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        wait_bit(CPB / 2);
        do_reset();
        return;
      end
      wait_bit(CPB);
    end
`ifdef SYNC_SERIAL_PARITY_EN
    rx = par;
    wait_bit(CPB);
`endif
    rx = stop;
    wait_bit(CPB);
    rx = 1'b1;
  endtask

  task automatic glitch(input int n);
    ev_t e;
    e.t_from = cyc + 3;
    e.t_end  = cyc + 3 + CPB / 2;
    e.kind   = 0;
    e.data   = '0;
    q.push_back(e);
    rx = 1'b0;
    wait_bit(n);
    rx = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_bit(3);
    rst_n = 1'b1;
    wait_bit(1);
    chk("reset_data",  32'(rx_data),   32'h0);
    chk("reset_busy",  32'(busy),      32'h0);
    wait_bit(10);

    send_frame(8'hA5, ^8'hA5, 1'b1, -1);
    wait_bit(20);
    chk("a5_data",  32'(rx_data), 32'hA5);
    chk("a5_valid", 32'(n_valid), 32'd1);
    chk("a5_err",   32'(n_err),   32'd0);

    send_frame(8'h3C, ^8'h3C, 1'b0, -1);
    wait_bit(20);
    chk("3c_keep", 32'(rx_data), 32'hA5);
    chk("3c_err",  32'(n_err),   32'd1);
    chk("3c_nov",  32'(n_valid), 32'd1);

    glitch(4);
    wait_bit(30);
    chk("glitch_v",    32'(n_valid), 32'd1);
    chk("glitch_e",    32'(n_err),   32'd1);
    chk("glitch_busy", 32'(busy),    32'h0);

    send_frame(8'h01, ^8'h01, 1'b1, -1);
    send_frame(8'hFF, ^8'hFF, 1'b1, -1);
    wait_bit(20);
    chk("b2b_data",  32'(rx_data), 32'hFF);
    chk("b2b_valid", 32'(n_valid), 32'd3);

    // Transmitter abandons the frame too, so the line returns high with the reset.
    send_frame(8'h55, ^8'h55, 1'b1, 3);
    chk("rst_data",  32'(rx_data),   32'h0);
    chk("rst_valid", 32'(rx_valid),  32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    wait_bit(20);
    chk("rst_nov", 32'(n_valid), 32'd3);
    send_frame(8'h0F, ^8'h0F, 1'b1, -1);
    wait_bit(20);
    chk("0f_data",  32'(rx_data), 32'h0F);
    chk("0f_valid", 32'(n_valid), 32'd4);

`ifdef SYNC_SERIAL_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1);
    wait_bit(20);
    chk("par_ok_data", 32'(rx_data), 32'h07);
    chk("par_ok_v",    32'(n_valid), 32'd5);
    send_frame(8'h07, 1'b0, 1'b1, -1);
    wait_bit(20);
    chk("par_bad_e",    32'(n_err),   32'd2);
    chk("par_bad_keep", 32'(rx_data), 32'h07);
`endif

    wait_bit(200);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
